intersection_sched: RTL

INTERSECTION_SCHED -- requirements
Module: intersection_sched

---
 rtl/intersection_sched_pkg.sv | 29 ++
 rtl/intersection_sched_if.sv | 30 +++
 rtl/intersection_sched_tick_gen.sv | 33 +++
 rtl/intersection_sched.sv | 137 +++++++++++++
 4 files changed

// File: rtl/intersection_sched_pkg.sv
// intersection_pkg: shared types and constants for the intersection scheduler.
//   phase_e        : phase encoding; the 3-bit code 7 is unused and treated as illegal
//   DEF_*          : default prescaler divide and phase durations in seconds
//   duration_ok()  : range check for a phase duration; sec_left is 6 bits wide
package intersection_pkg;

  typedef enum logic [2:0] {
    PH_NS_GREEN = 3'd0,
    PH_NS_YEL   = 3'd1,
    PH_ALLRED_A = 3'd2,
    PH_EW_GREEN = 3'd3,
    PH_EW_YEL   = 3'd4,
    PH_ALLRED_B = 3'd5,
    PH_PED_WALK = 3'd6
  } phase_e;

  localparam int DEF_TICK_DIV   = 10_000_000;
  localparam int DEF_NS_GREEN_S = 15;
  localparam int DEF_EW_GREEN_S = 10;
  localparam int DEF_YEL_S      = 3;
  localparam int DEF_ALLRED_S   = 1;
  localparam int DEF_WALK_S     = 8;
  localparam int SEC_MAX        = 63;

  function automatic bit duration_ok(input int d);
    return (d >= 1) && (d <= SEC_MAX);
  endfunction

endpackage

// File: rtl/intersection_sched_if.sv
// intersection_sched_if: request inputs and lamp/status outputs of the scheduler.
//   en, ew_car_req, ped_req      : enable, side-road sensor, pedestrian button
//   ns_*/ew_* lamps, walk        : decoded lamp drives
//   ped_wait, phase, sec_left    : status
// master = environment driving requests, slave = the scheduler.
interface intersection_sched_if;
  logic       en;
  logic       ew_car_req;
  logic       ped_req;
  logic       ns_red;
  logic       ns_yel;
  logic       ns_grn;
  logic       ew_red;
  logic       ew_yel;
  logic       ew_grn;
  logic       walk;
  logic       ped_wait;
  logic [2:0] phase;
  logic [5:0] sec_left;

  modport master (
    output en, ew_car_req, ped_req,
    input  ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, walk, ped_wait, phase, sec_left
  );

  modport slave (
    input  en, ew_car_req, ped_req,
    output ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, walk, ped_wait, phase, sec_left
  );
endinterface

// File: rtl/intersection_sched_tick_gen.sv
// tick_gen: one-second prescaler.
//   clk, rst (sync, active high), en -> tick
// Counts 0..TICK_DIV-1 while en is high; tick is high for the single cycle the
// count sits at TICK_DIV-1, and the count wraps on that edge. With en low the
// count holds and tick is suppressed, so no tick is created or lost by a freeze.
module tick_gen
  import intersection_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_sched.sv
// intersection_sched: traffic-light phase scheduler for a main (NS) / side (EW)
// road crossing with a pedestrian walk phase.
//   clk, rst (sync, active high)
//   bus (slave): en, ew_car_req, ped_req in; lamps, walk, ped_wait, phase, sec_left out
//
// phase       | meaning
// ------------+---------------------------------------------------------------
// NS_GREEN  0 | rest phase; main road green, leaves only on a request
// NS_YEL    1 | main road yellow
// ALLRED_A  2 | clearance, then walk if a pedestrian waits, else side road
// EW_GREEN  3 | side road green
// EW_YEL    4 | side road yellow
// ALLRED_B  5 | clearance back to main road; also reset / recovery phase
// PED_WALK  6 | pedestrian walk, all vehicle lamps red
module intersection_sched
  import intersection_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int NS_GREEN_S = DEF_NS_GREEN_S,
  parameter int EW_GREEN_S = DEF_EW_GREEN_S,
  parameter int YEL_S      = DEF_YEL_S,
  parameter int ALLRED_S   = DEF_ALLRED_S,
  parameter int WALK_S     = DEF_WALK_S
) (
  input  logic                 clk,
  input  logic                 rst,
  intersection_sched_if.slave  bus
);

  if (!duration_ok(NS_GREEN_S) || !duration_ok(EW_GREEN_S) || !duration_ok(YEL_S) ||
      !duration_ok(ALLRED_S) || !duration_ok(WALK_S) || (TICK_DIV < 1)) begin : g_bad_param
    $error("intersection_sched: phase durations must be 1..63 s and TICK_DIV >= 1");
  end

  localparam logic [5:0] NS_GREEN_D = 6'(NS_GREEN_S);
  localparam logic [5:0] EW_GREEN_D = 6'(EW_GREEN_S);
  localparam logic [5:0] YEL_D      = 6'(YEL_S);
  localparam logic [5:0] ALLRED_D   = 6'(ALLRED_S);
  localparam logic [5:0] WALK_D     = 6'(WALK_S);

  function automatic logic [5:0] dur_of(input phase_e p);
    case (p)
      PH_NS_GREEN: return NS_GREEN_D;
      PH_NS_YEL:   return YEL_D;
      PH_EW_GREEN: return EW_GREEN_D;
      PH_EW_YEL:   return YEL_D;
      PH_PED_WALK: return WALK_D;
      default:     return ALLRED_D;
    endcase
  endfunction

  logic       tick;
  phase_e     phase_q, phase_d;
  logic [5:0] sec_q, sec_d;
  logic       ped_q, ped_d;
  logic       last_sec;
  logic       any_req;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_ALLRED_B;
      sec_q   <= ALLRED_D;
      ped_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sec_q   <= sec_d;
      ped_q   <= ped_d;
    end
  end

  // sec_left can only be 0 in the rest phase, so "<= 1" doubles as the
  // expiry test there and keeps other phases safe if a 0 ever appears.
  assign last_sec = (sec_q <= 6'd1);
  assign any_req  = ped_q || bus.ew_car_req;

  always_comb begin
    phase_d = phase_q;
    sec_d   = sec_q;
    ped_d   = ped_q;

    case (phase_q)
      PH_NS_GREEN: begin
        if (tick) begin
          if (last_sec) begin
            if (any_req) phase_d = PH_NS_YEL;
            else         sec_d   = '0;
          end else begin
            sec_d = sec_q - 6'd1;
          end
        end
      end
      PH_NS_YEL, PH_ALLRED_A, PH_EW_GREEN, PH_EW_YEL, PH_ALLRED_B, PH_PED_WALK: begin
        if (tick) begin
          if (last_sec) begin
            case (phase_q)
              PH_NS_YEL:   phase_d = PH_ALLRED_A;
              PH_ALLRED_A: phase_d = ped_q ? PH_PED_WALK : PH_EW_GREEN;
              PH_EW_GREEN: phase_d = PH_EW_YEL;
              PH_EW_YEL:   phase_d = PH_ALLRED_B;
              PH_PED_WALK: phase_d = PH_ALLRED_B;
              default:     phase_d = PH_NS_GREEN;
            endcase
          end else begin
            sec_d = sec_q - 6'd1;
          end
        end
      end
      // Illegal code recovers on the next edge even while frozen.
      default: phase_d = PH_ALLRED_B;
    endcase

    if (phase_d != phase_q) sec_d = dur_of(phase_d);

    if (bus.en && bus.ped_req) ped_d = 1'b1;
    // Entering the walk phase serves the request; this beats a same-cycle press.
    if ((phase_d == PH_PED_WALK) && (phase_q != PH_PED_WALK)) ped_d = 1'b0;
  end

  assign bus.ns_grn   = (phase_q == PH_NS_GREEN);
  assign bus.ns_yel   = (phase_q == PH_NS_YEL);
  assign bus.ns_red   = !(bus.ns_grn || bus.ns_yel);
  assign bus.ew_grn   = (phase_q == PH_EW_GREEN);
  assign bus.ew_yel   = (phase_q == PH_EW_YEL);
  assign bus.ew_red   = !(bus.ew_grn || bus.ew_yel);
  assign bus.walk     = (phase_q == PH_PED_WALK);
  assign bus.ped_wait = ped_q;
  assign bus.phase    = phase_q;
  assign bus.sec_left = sec_q;

endmodule
